// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory requesters (CPU MEM stage, UART
// loader/dumper), the shared DataMemory port and the arbiter.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // Handshake: *_req is a level request and *_gnt answers it in the same
    // cycle; the access happens in every cycle where req & gnt are both high,
    // and a requester without gnt holds req/we/addr/wdata stable until granted.
    logic              boot_done;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;

    logic              uart_req;
    logic              uart_we;
    logic              uart_lock;
    logic [ADDR_W-1:0] uart_addr;
    logic [DATA_W-1:0] uart_wdata;
    logic              uart_gnt;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;

    logic [CNT_W-1:0]  conflict_cnt;

    modport slave (
        input  boot_done,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  uart_req, uart_we, uart_lock, uart_addr, uart_wdata,
        output cpu_gnt, cpu_stall, uart_gnt,
        output mem_addr, mem_wdata, mem_we, mem_re,
        output conflict_cnt
    );

    modport master (
        output boot_done,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output uart_req, uart_we, uart_lock, uart_addr, uart_wdata,
        input  cpu_gnt, cpu_stall, uart_gnt,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        input  conflict_cnt
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Cycle-by-cycle arbiter for the single DataMemory port: UART-only during boot,
// CPU priority at run time with UART starvation protection and burst lock.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    dmem_port_arbiter_if.slave                  bus,
    output logic [1:0]                          owner_dbg,
    output logic [$clog2(STARVE_LIMIT+1)-1:0]   wait_cnt_dbg
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_UART = 2'd2
    } owner_t;

    owner_t             owner_q, owner_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   conflict_q, conflict_d;

    logic               cpu_win;
    logic               uart_win;
    logic [ADDR_W-1:0]  addr_mux;
    logic [DATA_W-1:0]  wdata_mux;
    logic               we_mux;
    logic               re_mux;
    logic               stall_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= OWN_NONE;
            wait_q     <= '0;
            conflict_q <= '0;
        end else begin
            owner_q    <= owner_d;
            wait_q     <= wait_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        cpu_win    = 1'b0;
        uart_win   = 1'b0;
        addr_mux   = '0;
        wdata_mux  = '0;
        we_mux     = 1'b0;
        re_mux     = 1'b0;
        stall_c    = 1'b0;
        owner_d    = OWN_NONE;
        wait_d     = wait_q;
        conflict_d = conflict_q;

        // Grants are forced low while reset is held so nothing reaches memory.
        if (reset) begin
            cpu_win  = 1'b0;
            uart_win = 1'b0;
        end else if (!bus.boot_done) begin
            uart_win = bus.uart_req;
        end else if (owner_q == OWN_UART && bus.uart_lock && bus.uart_req) begin
            uart_win = 1'b1;
        end else if (bus.cpu_req && bus.uart_req && wait_q == WAIT_MAX) begin
            uart_win = 1'b1;
        end else if (bus.cpu_req) begin
            cpu_win = 1'b1;
        end else if (bus.uart_req) begin
            uart_win = 1'b1;
        end

        if (cpu_win) begin
            addr_mux  = bus.cpu_addr;
            wdata_mux = bus.cpu_wdata;
            we_mux    = bus.cpu_we;
            re_mux    = ~bus.cpu_we;
        end else if (uart_win) begin
            addr_mux  = bus.uart_addr;
            wdata_mux = bus.uart_wdata;
            we_mux    = bus.uart_we;
            re_mux    = ~bus.uart_we;
        end

        stall_c = bus.cpu_req & ~cpu_win & ~reset;

        if (cpu_win)       owner_d = OWN_CPU;
        else if (uart_win) owner_d = OWN_UART;

        // A UART that loses while still requesting ages toward a forced win.
        if (uart_win || !bus.uart_req) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
        end

        if (bus.cpu_req && bus.uart_req && bus.boot_done && conflict_q != '1) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    assign bus.cpu_gnt      = cpu_win;
    assign bus.uart_gnt     = uart_win;
    assign bus.cpu_stall    = stall_c;
    assign bus.mem_addr     = addr_mux;
    assign bus.mem_wdata    = wdata_mux;
    assign bus.mem_we       = we_mux;
    assign bus.mem_re       = re_mux;
    assign bus.conflict_cnt = conflict_q;

    assign owner_dbg    = owner_q;
    assign wait_cnt_dbg = wait_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: boot/reset, CPU priority, starvation,
// burst lock, idle port, counter saturation (second instance, CNT_W=4), boot drop.
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bif ();
    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(4))  sif ();

    logic [1:0] owner_dbg, sat_owner_dbg;
    logic [2:0] wait_dbg, sat_wait_dbg;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bif),
        .owner_dbg(owner_dbg), .wait_cnt_dbg(wait_dbg)
    );

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .bus(sif),
        .owner_dbg(sat_owner_dbg), .wait_cnt_dbg(sat_wait_dbg)
    );

    // The saturation instance sees exactly the same requests as the main one.
    assign sif.boot_done  = bif.boot_done;
    assign sif.cpu_req    = bif.cpu_req;
    assign sif.cpu_we     = bif.cpu_we;
    assign sif.cpu_addr   = bif.cpu_addr;
    assign sif.cpu_wdata  = bif.cpu_wdata;
    assign sif.uart_req   = bif.uart_req;
    assign sif.uart_we    = bif.uart_we;
    assign sif.uart_lock  = bif.uart_lock;
    assign sif.uart_addr  = bif.uart_addr;
    assign sif.uart_wdata = bif.uart_wdata;

    int vectors    = 0;
    int miscompares = 0;
    int exp_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset          = 1'b1;
        bif.boot_done  = 1'b0;
        bif.cpu_req    = 1'b0;
        bif.cpu_we     = 1'b0;
        bif.cpu_addr   = '0;
        bif.cpu_wdata  = '0;
        bif.uart_req   = 1'b0;
        bif.uart_we    = 1'b0;
        bif.uart_lock  = 1'b0;
        bif.uart_addr  = '0;
        bif.uart_wdata = '0;
        tick();
        tick();
        chk("rst_owner", 32'(owner_dbg), 32'd0);
        chk("rst_wait", 32'(wait_dbg), 32'd0);
        chk("rst_conflict", 32'(bif.conflict_cnt), 32'd0);
        reset = 1'b0;

        // Reset asserted mid-cycle while the UART is loading, then released.
        bif.uart_req   = 1'b1;
        bif.uart_we    = 1'b1;
        bif.uart_addr  = 32'h10;
        bif.uart_wdata = 32'hA5;
        bif.cpu_req    = 1'b1;
        bif.cpu_addr   = 32'h40;
        #1;
        chk("boot_pre_uart_gnt", 32'(bif.uart_gnt), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_uart_gnt", 32'(bif.uart_gnt), 32'd0);
        chk("rst_cpu_gnt", 32'(bif.cpu_gnt), 32'd0);
        chk("rst_mem_we", 32'(bif.mem_we), 32'd0);
        chk("rst_mem_re", 32'(bif.mem_re), 32'd0);
        chk("rst_mem_addr", bif.mem_addr, 32'd0);
        chk("rst_mem_wdata", bif.mem_wdata, 32'd0);
        chk("rst_cpu_stall", 32'(bif.cpu_stall), 32'd0);
        tick();
        chk("rst_mid_owner", 32'(owner_dbg), 32'd0);
        reset = 1'b0;
        #1;
        chk("boot_uart_gnt", 32'(bif.uart_gnt), 32'd1);
        chk("boot_cpu_gnt", 32'(bif.cpu_gnt), 32'd0);
        chk("boot_mem_we", 32'(bif.mem_we), 32'd1);
        chk("boot_mem_addr", bif.mem_addr, 32'h10);
        chk("boot_mem_wdata", bif.mem_wdata, 32'hA5);
        chk("boot_cpu_stall", 32'(bif.cpu_stall), 32'd1);
        tick();
        chk("boot_owner", 32'(owner_dbg), 32'd2);
        chk("boot_no_conflict", 32'(bif.conflict_cnt), 32'd0);

        // CPU priority for four contended cycles, then the starved UART wins.
        bif.boot_done = 1'b1;
        bif.uart_we   = 1'b0;
        bif.uart_addr = 32'h80;
        bif.cpu_we    = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("prio_cpu_gnt", 32'(bif.cpu_gnt), 32'd1);
            chk("prio_uart_gnt", 32'(bif.uart_gnt), 32'd0);
            chk("prio_mem_re", 32'(bif.mem_re), 32'd1);
            chk("prio_mem_addr", bif.mem_addr, 32'h40);
            tick();
            chk("prio_wait", 32'(wait_dbg), 32'(i));
        end
        #1;
        chk("starve_uart_gnt", 32'(bif.uart_gnt), 32'd1);
        chk("starve_cpu_gnt", 32'(bif.cpu_gnt), 32'd0);
        chk("starve_cpu_stall", 32'(bif.cpu_stall), 32'd1);
        chk("starve_mem_addr", bif.mem_addr, 32'h80);
        tick();
        chk("starve_wait", 32'(wait_dbg), 32'd0);
        chk("starve_conflict", 32'(bif.conflict_cnt), 32'd5);
        chk("starve_sat_conflict", 32'(sif.conflict_cnt), 32'd5);
        chk("starve_owner", 32'(owner_dbg), 32'd2);

        // Burst lock keeps the UART on the port despite the waiting CPU.
        bif.uart_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bif.uart_addr = 32'h100 + 32'(4 * i);
            #1;
            chk("lock_uart_gnt", 32'(bif.uart_gnt), 32'd1);
            chk("lock_cpu_stall", 32'(bif.cpu_stall), 32'd1);
            chk("lock_mem_addr", bif.mem_addr, 32'h100 + 32'(4 * i));
            tick();
        end
        bif.uart_lock = 1'b0;
        #1;
        chk("unlock_cpu_gnt", 32'(bif.cpu_gnt), 32'd1);
        chk("unlock_uart_gnt", 32'(bif.uart_gnt), 32'd0);
        chk("unlock_mem_addr", bif.mem_addr, 32'h40);
        tick();
        chk("unlock_wait", 32'(wait_dbg), 32'd1);
        chk("unlock_conflict", 32'(bif.conflict_cnt), 32'd9);
        chk("unlock_owner", 32'(owner_dbg), 32'd1);

        // CPU alone writes every cycle, then the port goes idle.
        bif.uart_req  = 1'b0;
        bif.cpu_we    = 1'b1;
        bif.cpu_addr  = 32'h44;
        bif.cpu_wdata = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("solo_cpu_gnt", 32'(bif.cpu_gnt), 32'd1);
            chk("solo_cpu_stall", 32'(bif.cpu_stall), 32'd0);
            chk("solo_mem_we", 32'(bif.mem_we), 32'd1);
            chk("solo_mem_re", 32'(bif.mem_re), 32'd0);
            chk("solo_mem_wdata", bif.mem_wdata, 32'h1234);
            tick();
        end
        chk("solo_wait", 32'(wait_dbg), 32'd0);
        bif.cpu_req = 1'b0;
        #1;
        chk("idle_mem_we", 32'(bif.mem_we), 32'd0);
        chk("idle_mem_re", 32'(bif.mem_re), 32'd0);
        chk("idle_mem_addr", bif.mem_addr, 32'd0);
        chk("idle_mem_wdata", bif.mem_wdata, 32'd0);
        chk("idle_gnts", 32'({bif.cpu_gnt, bif.uart_gnt}), 32'd0);
        tick();
        chk("idle_owner", 32'(owner_dbg), 32'd0);

        // uart_lock without uart_req releases ownership.
        bif.uart_req  = 1'b1;
        bif.uart_lock = 1'b1;
        bif.uart_addr = 32'h200;
        #1;
        chk("lockidle_uart_gnt", 32'(bif.uart_gnt), 32'd1);
        tick();
        chk("lockidle_owner_uart", 32'(owner_dbg), 32'd2);
        bif.uart_req = 1'b0;
        #1;
        chk("lockidle_no_gnt", 32'(bif.uart_gnt), 32'd0);
        chk("lockidle_mem_re", 32'(bif.mem_re), 32'd0);
        tick();
        chk("lockidle_owner_none", 32'(owner_dbg), 32'd0);
        bif.uart_req = 1'b1;
        bif.cpu_req  = 1'b1;
        bif.cpu_we   = 1'b0;
        bif.cpu_addr = 32'h48;
        #1;
        chk("lockidle_cpu_wins", 32'(bif.cpu_gnt), 32'd1);
        tick();
        chk("lockidle_conflict", 32'(bif.conflict_cnt), 32'd10);
        chk("lockidle_wait", 32'(wait_dbg), 32'd1);
        bif.uart_lock = 1'b0;

        // Twenty contended cycles: CPU x4 then UART, counters saturate.
        exp_w = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("sat_uart_gnt", 32'(bif.uart_gnt), 32'(exp_w == 4));
            chk("sat_cpu_gnt", 32'(bif.cpu_gnt), 32'(exp_w != 4));
            exp_w = (exp_w == 4) ? 0 : exp_w + 1;
            tick();
            chk("sat_wait", 32'(wait_dbg), 32'(exp_w));
            if (i == 4) chk("sat_small_at_limit", 32'(sif.conflict_cnt), 32'd15);
        end
        chk("sat_small_conflict", 32'(sif.conflict_cnt), 32'd15);
        chk("sat_main_conflict", 32'(bif.conflict_cnt), 32'd30);
        bif.uart_req = 1'b0;
        #1;
        chk("drop_uart_cpu_gnt", 32'(bif.cpu_gnt), 32'd1);
        tick();
        chk("drop_uart_wait", 32'(wait_dbg), 32'd0);
        chk("drop_uart_conflict", 32'(bif.conflict_cnt), 32'd30);

        // boot_done falls while the CPU is writing.
        bif.uart_req   = 1'b1;
        bif.uart_we    = 1'b0;
        bif.uart_addr  = 32'h300;
        bif.cpu_we     = 1'b1;
        bif.cpu_addr   = 32'h50;
        bif.cpu_wdata  = 32'hBEEF;
        #1;
        chk("bootdrop_pre_cpu_gnt", 32'(bif.cpu_gnt), 32'd1);
        chk("bootdrop_pre_mem_we", 32'(bif.mem_we), 32'd1);
        tick();
        bif.boot_done = 1'b0;
        #1;
        chk("bootdrop_cpu_gnt", 32'(bif.cpu_gnt), 32'd0);
        chk("bootdrop_uart_gnt", 32'(bif.uart_gnt), 32'd1);
        chk("bootdrop_mem_we", 32'(bif.mem_we), 32'd0);
        chk("bootdrop_mem_re", 32'(bif.mem_re), 32'd1);
        chk("bootdrop_mem_addr", bif.mem_addr, 32'h300);
        chk("bootdrop_cpu_stall", 32'(bif.cpu_stall), 32'd1);
        tick();
        chk("bootdrop_conflict", 32'(bif.conflict_cnt), 32'd31);
        chk("bootdrop_owner", 32'(owner_dbg), 32'd2);
        bif.uart_req = 1'b0;
        #1;
        chk("boot_idle_uart_gnt", 32'(bif.uart_gnt), 32'd0);
        chk("boot_idle_cpu_stall", 32'(bif.cpu_stall), 32'd1);
        tick();
        chk("boot_idle_conflict", 32'(bif.conflict_cnt), 32'd31);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the CPU MEM stage and the UART loader/dumper.
- Replaces the static recv_done address/data/write-enable mux in front of DataMemory with a cycle-by-cycle arbiter. The arbiter provides:
  - UART-exclusive ownership during boot,
  - CPU priority at run time, with starvation protection for the UART,
  - a UART burst lock,
  - a CPU stall output that feeds the pipeline hazard logic.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, write/read data width.
- STARVE_LIMIT, 4, consecutive lost cycles after which a waiting UART request beats the CPU.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- boot_done  in  1  high once the UART boot load is finished (driven by recv_done).
- cpu_req  in  1  CPU MEM stage needs the port this cycle (MemRead|MemWrite).
- cpu_we  in  1  CPU access is a write.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_gnt  out  1  CPU owns the port this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the pipeline.
- uart_req  in  1  UART engine access request.
- uart_we  in  1  UART access is a write.
- uart_lock  in  1  UART asks to keep ownership for its next request (burst).
- uart_addr  in  ADDR_W  UART byte address.
- uart_wdata  in  DATA_W  UART write data.
- uart_gnt  out  1  UART owns the port this cycle.
- mem_addr  out  ADDR_W  address to DataMemory.
- mem_wdata  out  DATA_W  write data to DataMemory.
- mem_we  out  1  write enable to DataMemory.
- mem_re  out  1  read enable to DataMemory.
- conflict_cnt  out  CNT_W  saturating count of cycles in which both requesters were active.

Behaviour:
- **Registered state:**
  - owner ∈ {NONE, CPU, UART}: owner of the previous cycle.
  - wait_cnt: 0..STARVE_LIMIT, saturating.
  - conflict_cnt.
- **Reset:** all registered state clears asynchronously to owner=NONE, wait_cnt=0, conflict_cnt=0.
  - While reset is high, cpu_gnt=0, uart_gnt=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, cpu_stall=0.
  - Reset asserted mid-burst drops the grant immediately; no partial-state carry-over.
- **Grant decision:** combinational, evaluated in priority order; zero-latency for the winner.
  1. boot_done=0: uart_gnt=uart_req; cpu_gnt=0.
  2. owner=UART & uart_lock & uart_req: UART wins.
  3. cpu_req & uart_req & wait_cnt==STARVE_LIMIT: UART wins.
  4. cpu_req: CPU wins.
  5. uart_req: UART wins.
  6. Otherwise: no grant.
- **Grant exclusivity:** cpu_gnt and uart_gnt are never both 1.
- **Memory port drive:**
  - The winner's addr and wdata are driven to mem_addr/mem_wdata.
  - mem_we = winner's we.
  - mem_re = ~winner's we.
  - With no winner, all port outputs are 0.
- **Read data:** DataMemory read is combinational, so read data is valid in the grant cycle. The requester samples Read_data only when its gnt is high. The arbiter does not register read data.
- **owner update (next clk):** CPU if cpu_gnt, UART if uart_gnt, else NONE.
- **wait_cnt update:**
  - Clears when uart_gnt=1 or uart_req=0.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - It therefore reaches STARVE_LIMIT after STARVE_LIMIT lost cycles; the next contended cycle goes to the UART.
- **conflict_cnt:** increments on every cycle with cpu_req & uart_req & boot_done, and holds at all-ones.
- **boot_done falling edge (re-entering boot mode):** the CPU loses the port the same cycle and cpu_stall follows cpu_req.
- **uart_lock without uart_req:** ownership is released; no grant is reserved for idle cycles.
- **Requester stability:** a stalled CPU keeps req/addr/wdata stable until granted (pipeline contract). The arbiter stores nothing on the requesters' behalf.

Test Plan:
1. **Reset and boot load.** Assert reset mid-cycle with uart_req=1, then release with boot_done=0, uart_req=1, uart_we=1, uart_addr=0x10, uart_wdata=0xA5, cpu_req=1.
   - During reset: all grants 0.
   - After release: uart_gnt=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5, cpu_stall=1.
2. **CPU priority.** boot_done=1, cpu_req=1 (read 0x40), uart_req=1.
   - Cycles 1-4: cpu_gnt=1, mem_re=1, mem_addr=0x40, wait_cnt=1..4.
   - Cycle 5: uart_gnt=1, cpu_stall=1, wait_cnt→0.
   - conflict_cnt=5.
3. **Burst lock.** UART granted with uart_lock=1 for 3 consecutive requests while cpu_req=1.
   - UART holds the port for all 3 cycles.
   - The CPU is granted in the cycle after uart_lock=0.
4. **Single requester.** Only cpu_req: cpu_gnt=1 every cycle and cpu_stall=0. Then no requests: mem_we=mem_re=0, mem_addr=0, owner=NONE.
5. **Saturation.** With CNT_W=4 forced, hold both requests for 20 cycles: conflict_cnt stops at 15. Then drop uart_req: wait_cnt clears to 0.
6. **boot_done drop.** Drop boot_done while the CPU is writing: cpu_gnt→0 and mem_we follows uart_we in the same cycle.
